// File: rtl/sig_analyzer_16.sv
// sig_analyzer_16 - serial signature analyzer (16-bit LFSR compactor).
//
// Compacts a serial bit stream into a 16-bit signature between a start and a
// stop strobe, using the feedback polynomial x^16 + x^12 + x^9 + x^7 + 1.
//
// Ports:
//   clk    in   1   rising-edge clock for all state
//   rst    in   1   synchronous active-high reset
//   d      in   1   serial data bit, sampled on the rising edge
//   start  in   1   begins (or restarts) a capture window
//   stop   in   1   ends the current capture window
//   exp    in  16   expected signature
//   sig    out 16   signature register
//   count  out 16   bits compacted in the current/last window (saturating)
//   busy   out  1   capture window open
//   valid  out  1   capture complete, sig/count frozen
//   ovf    out  1   sticky: a shift happened while count was saturated
//   pass   out  1   valid and sig matches exp

module sig_analyzer_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        d,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] exp,
    output logic [15:0] sig,
    output logic [15:0] count,
    output logic        busy,
    output logic        valid,
    output logic        ovf,
    output logic        pass
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q;
    logic [15:0] sig_q;
    logic [15:0] count_q;
    logic        busy_q;
    logic        valid_q;
    logic        ovf_q;

    logic        fb;
    logic        count_sat;

    // Fibonacci-style feedback: taps at bits 6, 8, 11 and 15 of the register
    // before the shift, xored with the incoming data bit.
    assign fb        = d ^ sig_q[6] ^ sig_q[8] ^ sig_q[11] ^ sig_q[15];
    assign count_sat = (count_q == 16'hFFFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sig_q   <= 16'h0000;
            count_q <= 16'h0000;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    // start beats a simultaneous stop; stop alone is ignored here
                    if (start) begin
                        state_q <= StRun;
                        sig_q   <= 16'h0000;
                        count_q <= 16'h0000;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (start) begin
                        // restart: clear and stay in RUN, no shift on this edge
                        sig_q   <= 16'h0000;
                        count_q <= 16'h0000;
                        ovf_q   <= 1'b0;
                    end else if (stop) begin
                        // stop edge is exclusive: d on this edge is not compacted
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        sig_q <= {sig_q[14:0], fb};
                        if (count_sat) begin
                            ovf_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 16'd1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sig   = sig_q;
    assign count = count_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign pass  = valid_q && (sig_q == exp);

endmodule

// File: tb/tb_sig_analyzer_16.sv
// Testbench for sig_analyzer_16: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.

module tb_sig_analyzer_16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        d = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] exp = 16'h0000;
    logic [15:0] sig;
    logic [15:0] count;
    logic        busy;
    logic        valid;
    logic        ovf;
    logic        pass;

    int n_cmp = 0;
    int n_bad = 0;

    sig_analyzer_16 dut (
        .clk   (clk),
        .rst   (rst),
        .d     (d),
        .start (start),
        .stop  (stop),
        .exp   (exp),
        .sig   (sig),
        .count (count),
        .busy  (busy),
        .valid (valid),
        .ovf   (ovf),
        .pass  (pass)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 = idle, 1 = capturing, 2 = finished.
    int          m_mode  = 0;
    logic [15:0] m_sig   = 16'h0000;
    int          m_cnt   = 0;
    bit          m_ovf   = 1'b0;
    bit          m_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode  = 0;
            m_sig   = 16'h0000;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1;
                m_sig  = 16'h0000;
                m_cnt  = 0;
                m_ovf  = 1'b0;
            end
        end else if (start) begin
            m_sig = 16'h0000;
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (stop) begin
            m_mode = 2;
        end else begin
            m_sig = {m_sig[14:0], d ^ m_sig[6] ^ m_sig[8] ^ m_sig[11] ^ m_sig[15]};
            if (m_cnt == 65535) m_ovf = 1'b1;
            else m_cnt = m_cnt + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_known) begin
            logic [15:0] w_cnt;
            logic        w_pass;
            w_cnt  = m_cnt[15:0];
            w_pass = (m_mode == 2) && (m_sig == exp);
            n_cmp++;
            if (sig !== m_sig || count !== w_cnt || busy !== (m_mode == 1) ||
                valid !== (m_mode == 2) || ovf !== m_ovf || pass !== w_pass) begin
                n_bad++;
                $display("FAIL cycle t=%0t: got sig=%h cnt=%h b=%b v=%b o=%b p=%b want sig=%h cnt=%h b=%b v=%b o=%b p=%b",
                         $time, sig, count, busy, valid, ovf, pass,
                         m_sig, w_cnt, (m_mode == 1), (m_mode == 2), m_ovf, w_pass);
            end
        end
    end

    task automatic step(input logic st, input logic sp, input logic dd, input logic r);
        start = st;
        stop  = sp;
        d     = dd;
        rst   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(1, 1, 1, 1);
        check("reset_sig", sig, 0);
        check("reset_count", count, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_ovf", ovf, 0);
        check("reset_pass", pass, 0);
        step(0, 1, 1, 0);
        check("idle_stop_ignored", {busy, valid}, 0);

        // Single bit window
        step(1, 0, 0, 0);
        check("start_busy", busy, 1);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check("one_sig", sig, 16'h0001);
        check("one_count", count, 16'h0001);
        check("one_valid", valid, 1);
        check("one_busy", busy, 0);
        exp = 16'h0001; #1;
        check("one_pass1", pass, 1);
        exp = 16'h0002; #1;
        check("one_pass0", pass, 0);
        // DONE holds through d and stop activity
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        check("done_hold_sig", sig, 16'h0001);
        check("done_hold_count", count, 16'h0001);

        // Marker walks up; taps feed back once it passes bit 6.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("walk16_sig", sig, 16'h814A);
        check("walk16_count", count, 16);
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("walk17_sig", sig, 16'h0295);
        check("walk17_count", count, 17);

        // Zero stream
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        exp = 16'h0000; #1;
        check("zero_sig", sig, 0);
        check("zero_count", count, 20);
        check("zero_pass", pass, 1);

        // Restart with start and stop together
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        step(1, 1, 1, 0);
        check("restart_busy", busy, 1);
        check("restart_count", count, 0);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check("restart_sig", sig, 16'h0001);
        check("restart_count2", count, 1);

        // Reset mid-run beats start
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 0, 1, 1);
        check("midrst_busy", busy, 0);
        check("midrst_sig", sig, 0);
        check("midrst_count", count, 0);
        step(0, 1, 0, 0);
        check("midrst_stop_idle", {busy, valid}, 0);

        // Randomized phase
        for (int i = 0; i < 8000; i++) begin
            logic r, st, sp, dd;
            r  = ($urandom_range(0, 499) == 0);
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 11) == 0);
            dd = 1'($urandom_range(0, 1));
            exp = ($urandom_range(0, 1) == 1) ? m_sig : 16'($urandom);
            step(st, sp, dd, r);
        end

        // Saturation
        step(1, 0, 0, 0);
        for (int i = 0; i < 65535; i++) step(0, 0, 0, 0);
        check("sat_edge_ovf", ovf, 0);
        check("sat_edge_count", count, 16'hFFFF);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        check("sat_count", count, 16'hFFFF);
        check("sat_ovf", ovf, 1);
        check("sat_sig", sig, 0);
        check("sat_valid", valid, 1);
        step(1, 0, 0, 0);
        check("sat_clear_ovf", ovf, 0);
        check("sat_clear_count", count, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
